bidir_bus_port: RTL
===================

// Module: bidir_bus_port
// PURPOSE
//   Registered WIDTH-bit bidirectional bus port: the return direction paired with the 4-bit one-way bus.
//   Listens to the shared tri-state bus and captures words, or drives local data onto it on request.
//   Inserts TURN_CYCLES of all-Z turnaround on every direction change so two ends never drive together.
//   Sits between local logic and the shared inout bus pins.
// PARAMETERS
//   WIDTH        4  bus/data width in bits
//   TURN_CYCLES  1  idle (Z) cycles per direction change; legal range 1..15
// PORTS
//   clk       in     1      system clock, rising edge
//   rst       in     1      asynchronous, active-high reset
//   bus       inout  WIDTH  shared tri-state bus
//   dir       in     1      1 = request to drive bus, 0 = request to listen
//   tx_data   in     WIDTH  word to drive
//   tx_valid  in     1      tx_data valid
//   tx_ready  out    1      port accepts tx_data this cycle
//   rx_en     in     1      sample strobe while listening
//   rx_data   out    WIDTH  last captured bus word
//   rx_valid  out    1      one-cycle pulse: rx_data updated
//   oe        out    1      1 = this port is driving bus
//   busy      out    1      1 = in a turnaround state
// BEHAVIOUR
//   Reset (async, immediate): state=LISTEN, oe=0, bus=Z, drive_reg=0, rx_data=0, rx_valid=0,
//     tx_ready=0, busy=0, turnaround counter=0. Reset asserted in DRIVE releases bus at once, not at next edge.
//   State machine (registered): LISTEN, TURN_OUT, DRIVE, TURN_IN.
//   bus = oe ? drive_reg : {WIDTH{1'bz}}; oe = (state==DRIVE); busy = TURN_OUT or TURN_IN.
//   tx_ready = (state==DRIVE) && dir (combinational).
//   LISTEN: dir=1 -> TURN_OUT, counter loads TURN_CYCLES-1.
//     rx_en=1 -> rx_data<=bus, rx_valid<=1 at next edge (1-cycle latency); else rx_valid<=0.
//     dir=1 and rx_en=1 same cycle: sample still taken, transition still happens.
//   TURN_OUT: bus Z. Counter decrements; at 0 -> DRIVE.
//     dir=0 during TURN_OUT -> abort straight to LISTEN (never drove, no TURN_IN).
//   DRIVE: tx_valid && tx_ready -> drive_reg<=tx_data; new word on bus from next cycle.
//     dir=0 -> TURN_IN, counter loads TURN_CYCLES-1. A word accepted in the last dir=1 cycle is
//     still driven for exactly one cycle before release (state is DRIVE in that cycle).
//     drive_reg holds across cycles without handshake and across direction changes.
//   TURN_IN: bus Z; dir ignored; counter at 0 -> LISTEN.
//   rx_en ignored outside LISTEN; rx_valid is 0 in every non-LISTEN-captured cycle.
//   Total drive latency from dir rising in LISTEN: oe=1 after TURN_CYCLES+1 edges.
//   Counter width $clog2(TURN_CYCLES+1); no wrap: always reloaded before use.
// TESTING
//   Bench models far end with its own enable; assertion: never (oe==1 && far_oe==1) in any cycle.
//   1 Reset: rst=1 mid-sim at any state -> same cycle oe=0, bus=Z, rx_valid=0, tx_ready=0; state LISTEN.
//   2 Receive: far end drives 4'hA, rx_en=1 one cycle -> next edge rx_data=4'hA, rx_valid=1 for 1 cycle.
//   3 Turn out + send: dir=1 at T, TURN_CYCLES=1 -> busy=1 at T+1, oe=1 at T+2; tx_data=4'h5
//     tx_valid=1 -> bus=4'h5 next cycle; sweep tx_data 0..15 -> each appears on bus in order.
//   4 Release: dir=0 in DRIVE after accepting 4'hC -> bus=4'hC one cycle, then Z, busy=1 one cycle,
//     then LISTEN; far end drives 4'h3, rx_en=1 -> rx_data=4'h3.
//   5 Abort + simultaneity: dir=1 with rx_en=1 -> sample captured and TURN_OUT; dir=0 in TURN_OUT ->
//     LISTEN next edge, oe never 1. Repeat with TURN_CYCLES=3 -> oe rises 4 edges after dir.
//   6 Reset mid-DRIVE with bus=4'hF -> bus Z immediately; after release drive_reg=0, LISTEN.

Source files
------------

// File: rtl/bidir_bus_port_if.sv
// Local-side handshake bundle for bidir_bus_port.
// The shared tri-state pins are not part of this bundle. They stay a plain inout on the port
// module so that the resolved net lives where the physical pins are.
interface bidir_bus_port_if #(
    parameter int WIDTH = 4
);
    logic             dir;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             rx_en;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             oe;
    logic             busy;

    // Local logic that requests direction and supplies/consumes words
    modport master (
        output dir, tx_data, tx_valid, rx_en,
        input  tx_ready, rx_data, rx_valid, oe, busy
    );

    // The bus port itself
    modport slave (
        input  dir, tx_data, tx_valid, rx_en,
        output tx_ready, rx_data, rx_valid, oe, busy
    );
endinterface

// File: rtl/bidir_bus_port.sv
// Registered bidirectional bus port.
// The port listens to the shared bus and captures words on request, or drives a held local word
// onto the bus. Every change of direction passes through TURN_CYCLES all-Z cycles, so this end
// and the far end never drive the bus at the same time.
module bidir_bus_port #(
    parameter int WIDTH       = 4,
    parameter int TURN_CYCLES = 1   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    bidir_bus_port_if.slave  port
);
    localparam int            CW        = $clog2(TURN_CYCLES + 1);
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        LISTEN   = 2'd0,
        TURN_OUT = 2'd1,
        DRIVE    = 2'd2,
        TURN_IN  = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] drive_reg;
    logic [WIDTH-1:0] rx_data_r;
    logic             rx_valid_r;
    logic             oe_i;

    // oe and busy decode straight from the state register. An async reset therefore releases
    // the bus in the same cycle, without waiting for a clock edge.
    assign oe_i          = (state == DRIVE);
    assign port.oe       = oe_i;
    assign port.busy     = (state == TURN_OUT) || (state == TURN_IN);
    assign port.tx_ready = oe_i && port.dir;
    assign port.rx_data  = rx_data_r;
    assign port.rx_valid = rx_valid_r;
    assign bus           = oe_i ? drive_reg : {WIDTH{1'bz}};

    // Direction FSM, turnaround counter, drive holding register and receive capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LISTEN;
            cnt        <= '0;
            drive_reg  <= '0;
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            case (state)
                LISTEN: begin
                    // A sample and a turn request in the same cycle are both honoured.
                    if (port.rx_en) begin
                        rx_data_r  <= bus;
                        rx_valid_r <= 1'b1;
                    end
                    if (port.dir) begin
                        state <= TURN_OUT;
                        cnt   <= TURN_LOAD;
                    end
                end
                TURN_OUT: begin
                    // Dropping dir here aborts straight back to LISTEN. The port never drove
                    // the bus, so no inbound turnaround is needed.
                    if (!port.dir) begin
                        state <= LISTEN;
                    end else if (cnt == '0) begin
                        state <= DRIVE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DRIVE: begin
                    // drive_reg keeps its word until the next handshake, across idle cycles
                    // and direction changes alike.
                    if (port.tx_valid && port.dir) begin
                        drive_reg <= port.tx_data;
                    end
                    if (!port.dir) begin
                        state <= TURN_IN;
                        cnt   <= TURN_LOAD;
                    end
                end
                TURN_IN: begin
                    if (cnt == '0) begin
                        state <= LISTEN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= LISTEN;
            endcase
        end
    end
endmodule
